// File: rtl/spmv_seq_ctrl.sv
// spmv_seq_ctrl: walks one compressed sparse matrix (val/col/eor memories),
// issues reads, tracks row boundaries and emits pipeline-aligned row strobes.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; pipelines empty
//   ISSUE  | one read per non-stalled cycle, addr 0 .. nnz-1
//   DRAIN  | all reads issued, waiting for in-flight entries to retire
//   DONE   | one-cycle done pulse, busy already low
module spmv_seq_ctrl #(
  parameter int WIDTH_ADDR = 16,
  parameter int WIDTH_ROW  = 16,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [WIDTH_ADDR-1:0] nnz_cfg_i,
  input  logic                  stall_in_i,
  input  logic                  eor_in_i,
  output logic                  mem_rd_en_o,
  output logic [WIDTH_ADDR-1:0] mem_addr_o,
  output logic                  row_valid_o,
  output logic [WIDTH_ROW-1:0]  row_idx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH_ADDR-1:0] ADDR_ONE = WIDTH_ADDR'(1);
  localparam logic [WIDTH_ROW-1:0]  ROW_ONE  = WIDTH_ROW'(1);

  state_t                               state_q, state_d;
  logic [WIDTH_ADDR-1:0]                nnz_q, nnz_d;
  logic [WIDTH_ADDR-1:0]                addr_q, addr_d;
  logic [WIDTH_ROW-1:0]                 row_cnt_q, row_cnt_d;
  logic                                 rd_last_q, rd_last_d;
  // vld_pipe_q[0] is the read issued last cycle (its eor bit is on eor_in_i now)
  logic [PIPE_DEPTH-1:0]                vld_pipe_q, vld_pipe_d;
  logic [PIPE_DEPTH-1:0]                rv_pipe_q, rv_pipe_d;
  logic [PIPE_DEPTH-1:0][WIDTH_ROW-1:0] idx_pipe_q, idx_pipe_d;

  logic last_issue;
  logic row_end;
  logic flush;

  assign last_issue = (addr_q == (nnz_q - ADDR_ONE));
  // The last entry of the matrix always closes a row, whatever its eor bit says.
  assign row_end    = vld_pipe_q[0] & (eor_in_i | rd_last_q);
  assign flush      = abort_i & (state_q != S_IDLE);

  assign row_valid_o = rv_pipe_q[PIPE_DEPTH-1];
  assign row_idx_o   = rv_pipe_q[PIPE_DEPTH-1] ? idx_pipe_q[PIPE_DEPTH-1] : '0;

  // Next state, issue outputs and counter updates.
  always_comb begin
    state_d     = state_q;
    nnz_d       = nnz_q;
    addr_d      = addr_q;
    row_cnt_d   = row_end ? (row_cnt_q + ROW_ONE) : row_cnt_q;
    mem_rd_en_o = 1'b0;
    mem_addr_o  = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    rd_last_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          busy_o    = 1'b1;
          nnz_d     = nnz_cfg_i;
          addr_d    = '0;
          row_cnt_d = '0;
          state_d   = (nnz_cfg_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy_o = 1'b1;
        if (!stall_in_i) begin
          mem_rd_en_o = 1'b1;
          mem_addr_o  = addr_q;
          rd_last_d   = last_issue;
          if (last_issue) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        // Once the last stage has shifted out, the final row strobe is on the
        // output this cycle, so done lands exactly one cycle after it.
        if (vld_pipe_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // Issue-valid and row-end delay lines; abort empties them.
  always_comb begin
    vld_pipe_d    = '0;
    rv_pipe_d     = '0;
    idx_pipe_d    = '0;
    vld_pipe_d[0] = mem_rd_en_o;
    rv_pipe_d[0]  = row_end;
    idx_pipe_d[0] = row_cnt_q;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      rv_pipe_d[i]  = rv_pipe_q[i-1];
      idx_pipe_d[i] = idx_pipe_q[i-1];
    end
    if (flush) begin
      vld_pipe_d = '0;
      rv_pipe_d  = '0;
      idx_pipe_d = '0;
    end
  end

  // State, counters and delay-line registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nnz_q      <= '0;
      addr_q     <= '0;
      row_cnt_q  <= '0;
      rd_last_q  <= 1'b0;
      vld_pipe_q <= '0;
      rv_pipe_q  <= '0;
      idx_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      nnz_q      <= nnz_d;
      addr_q     <= addr_d;
      row_cnt_q  <= row_cnt_d;
      rd_last_q  <= flush ? 1'b0 : rd_last_d;
      vld_pipe_q <= vld_pipe_d;
      rv_pipe_q  <= rv_pipe_d;
      idx_pipe_q <= idx_pipe_d;
    end
  end

endmodule

// File: tb/tb_spmv_seq_ctrl.sv
// Bench for spmv_seq_ctrl: directed scenario table plus randomized passes,
// all checked cycle by cycle against an event-schedule model of the sequencer.
module tb_spmv_seq_ctrl;

  localparam int P = 3;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic [15:0] nnz_cfg_i;
  logic        stall_in_i;
  logic        eor_in_i;
  logic        mem_rd_en_o;
  logic [15:0] mem_addr_o;
  logic        row_valid_o;
  logic [15:0] row_idx_o;
  logic        busy_o;
  logic        done_o;

  spmv_seq_ctrl #(.WIDTH_ADDR(16), .WIDTH_ROW(16), .PIPE_DEPTH(P)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .nnz_cfg_i(nnz_cfg_i), .stall_in_i(stall_in_i), .eor_in_i(eor_in_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .row_valid_o(row_valid_o), .row_idx_o(row_idx_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: the pass is a phase (idle / issuing / draining / done) plus a
  // schedule of future row strobes keyed by absolute cycle.
  localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_DRAIN = 2, PH_DONE = 3;
  int          m_phase;
  int          m_nnz;
  int          m_addr;
  logic [15:0] m_rows;
  int          m_done_at;
  bit          m_prev_rd;
  int          m_prev_addr;
  bit          rv_ring [16];
  logic [15:0] idx_ring [16];
  bit          eor_bits [64];

  int obs_issues, obs_rows, obs_dones, obs_busy, obs_last;

  typedef struct {
    int          nnz;
    logic [31:0] eor;
    int          stall_after;
    int          stall_len;
    int          abort_at;
    int          busy_start_at;
    int          exp_issues;
    int          exp_rows;
    int          exp_dones;
    int          exp_busy;
    int          exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase     = PH_IDLE;
    m_nnz       = 0;
    m_addr      = 0;
    m_rows      = '0;
    m_done_at   = 0;
    m_prev_rd   = 1'b0;
    m_prev_addr = 0;
    for (int i = 0; i < 16; i++) begin
      rv_ring[i]  = 1'b0;
      idx_ring[i] = '0;
    end
  endtask

  // Called just after a falling edge: drive, check, advance model, wait one cycle.
  task automatic do_cycle(input bit st, input bit ab, input logic [15:0] nc, input bit stl);
    bit          e_rd, e_rv, e_busy, e_done;
    logic [15:0] e_addr, e_idx;
    int          slot;
    start_i    = st;
    abort_i    = ab;
    nnz_cfg_i  = nc;
    stall_in_i = stl;
    eor_in_i   = m_prev_rd ? eor_bits[m_prev_addr] : 1'($urandom);
    #1;
    slot   = cyc % 16;
    e_rd   = (m_phase == PH_ISSUE) && !stl;
    e_addr = e_rd ? 16'(m_addr) : 16'h0;
    e_rv   = rv_ring[slot];
    e_idx  = e_rv ? idx_ring[slot] : 16'h0;
    rv_ring[slot] = 1'b0;
    e_busy = (m_phase == PH_ISSUE) || (m_phase == PH_DRAIN) ||
             ((m_phase == PH_IDLE) && st && !ab);
    e_done = (m_phase == PH_DONE);

    chk("mem_rd_en", 32'(mem_rd_en_o), 32'(e_rd));
    chk("mem_addr",  32'(mem_addr_o),  32'(e_addr));
    chk("row_valid", 32'(row_valid_o), 32'(e_rv));
    chk("row_idx",   32'(row_idx_o),   32'(e_idx));
    chk("busy",      32'(busy_o),      32'(e_busy));
    chk("done",      32'(done_o),      32'(e_done));

    if (mem_rd_en_o) obs_issues++;
    if (row_valid_o) begin
      obs_rows++;
      obs_last = int'(row_idx_o);
    end
    if (done_o) obs_dones++;
    if (busy_o) obs_busy++;

    m_prev_rd   = e_rd;
    m_prev_addr = m_addr;
    if (m_phase != PH_IDLE && ab) begin
      m_phase = PH_IDLE;
      for (int i = 0; i < 16; i++) rv_ring[i] = 1'b0;
    end else begin
      case (m_phase)
        PH_IDLE: if (st) begin
          m_nnz   = int'(nc);
          m_addr  = 0;
          m_rows  = '0;
          m_phase = (nc == 16'h0) ? PH_DONE : PH_ISSUE;
        end
        PH_ISSUE: if (e_rd) begin
          if (eor_bits[m_addr] || m_addr == m_nnz - 1) begin
            rv_ring[(cyc + 1 + P) % 16]  = 1'b1;
            idx_ring[(cyc + 1 + P) % 16] = m_rows;
            m_rows = m_rows + 16'h1;
          end
          if (m_addr == m_nnz - 1) begin
            m_phase   = PH_DRAIN;
            m_done_at = cyc + 2 + P;
          end else begin
            m_addr++;
          end
        end
        PH_DRAIN: if (cyc + 1 == m_done_at) m_phase = PH_DONE;
        default:  m_phase = PH_IDLE;
      endcase
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_pass(input vec_t v, input bit rnd, input string name);
    int   stall_cnt;
    bit   stl, st, ab, finished;
    logic [15:0] nc;
    obs_issues = 0; obs_rows = 0; obs_dones = 0; obs_busy = 0; obs_last = -1;
    stall_cnt  = 0;
    finished   = 1'b0;
    for (int i = 0; i < 64; i++)
      eor_bits[i] = rnd ? 1'($urandom) : ((i < 32) ? v.eor[i] : 1'b0);
    for (int k = 0; k < 300; k++) begin
      st  = (k == 0) || (k == v.busy_start_at);
      nc  = (k == 0) ? 16'(v.nnz) : (rnd ? 16'($urandom_range(1, 30)) : 16'd9);
      ab  = (k == v.abort_at);
      stl = rnd ? ($urandom_range(0, 3) == 0) : (stall_cnt > 0);
      do_cycle(st, ab, nc, stl);
      if (stl && stall_cnt > 0) stall_cnt--;
      if (m_prev_rd && m_prev_addr == v.stall_after) stall_cnt = v.stall_len;
      if (m_phase == PH_IDLE) begin
        finished = 1'b1;
        break;
      end
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout got=phase%0d exp=idle", name, m_phase);
    end
    for (int k = 0; k < 2; k++)
      do_cycle(1'b0, rnd ? 1'($urandom) : 1'b0, 16'd0, 1'($urandom));
    if (!rnd) begin
      chk({name, ".issues"}, 32'(obs_issues), 32'(v.exp_issues));
      chk({name, ".rows"},   32'(obs_rows),   32'(v.exp_rows));
      chk({name, ".dones"},  32'(obs_dones),  32'(v.exp_dones));
      chk({name, ".busy"},   32'(obs_busy),   32'(v.exp_busy));
      chk({name, ".last"},   32'(obs_last),   32'(v.exp_last));
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, ".rd"},    32'(mem_rd_en_o), 32'h0);
    chk({name, ".addr"},  32'(mem_addr_o),  32'h0);
    chk({name, ".rv"},    32'(row_valid_o), 32'h0);
    chk({name, ".idx"},   32'(row_idx_o),   32'h0);
    chk({name, ".busy"},  32'(busy_o),      32'h0);
    chk({name, ".done"},  32'(done_o),      32'h0);
  endtask

  vec_t vecs [9];
  vec_t rv;

  initial begin
    //           nnz eor          stA stL abort bsy  iss rows dn busy last
    vecs[0] = '{5,  32'h12,      -1, 0,  -1,  -1,  5,  2,   1, 10,  1};
    vecs[1] = '{0,  32'h0,       -1, 0,  -1,  -1,  0,  0,   1, 1,  -1};
    vecs[2] = '{4,  32'h1,       -1, 0,  -1,  -1,  4,  2,   1, 9,   1};
    vecs[3] = '{6,  32'h4,        2, 3,  -1,  -1,  6,  2,   1, 14,  1};
    vecs[4] = '{8,  32'h1,       -1, 0,   2,  -1,  2,  0,   0, 3,  -1};
    vecs[5] = '{2,  32'h1,       -1, 0,  -1,  -1,  2,  2,   1, 7,   1};
    vecs[6] = '{3,  32'h2,       -1, 0,  -1,   2,  3,  2,   1, 8,   1};
    vecs[7] = '{1,  32'h0,       -1, 0,  -1,  -1,  1,  1,   1, 6,   0};
    vecs[8] = '{20, 32'hFFFFF,   -1, 0,  -1,  -1,  20, 20,  1, 25,  19};

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; nnz_cfg_i = '0;
    stall_in_i = 1'b0; eor_in_i = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_pass(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a pass, then a clean restart.
    eor_bits[0] = 1'b1;
    do_cycle(1'b1, 1'b0, 16'd10, 1'b0);
    repeat (4) do_cycle(1'b0, 1'b0, 16'd0, 1'b0);
    start_i = 1'b0; abort_i = 1'b0; stall_in_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc += 2;
    run_pass(vecs[5], 1'b0, "after_reset");

    // Randomized passes with stalls, aborts and starts while busy.
    for (int n = 0; n < 150; n++) begin
      rv = '{0, 32'h0, -1, 0, -1, -1, 0, 0, 0, 0, 0};
      rv.nnz           = $urandom_range(0, 24);
      rv.abort_at      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : -1;
      rv.busy_start_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
      run_pass(rv, 1'b1, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
